data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
- Memory-side responder for the pipeline's data-SRAM port: accepts the SRAM-style request (enable, byte write-enable, address, write data) driven by the execute stage and returns read data.
- Converts each request into one transaction on a variable-latency request/grant/response bus.
- Holds the pipeline with stallreq until that transaction completes.
- Sits between the core's data-SRAM pins and the data bus arbiter.

Parameters:
- TIMEOUT, 255, cycles spent waiting in ADDR plus RESP before a transaction is aborted; 8-bit counter; must be ≥1.
- ERR_RDATA, 32'h0000_0000, read data returned on a timed-out read.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- data_sram_en  in  1  access request from execute stage
- data_sram_wen  in  4  byte write enables; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  store data, already lane-aligned
- data_sram_rdata  out  32  load data, valid from the cycle after stallreq drops
- stallreq  out  1  pipeline stall request
- bus_req  out  1  address-phase valid
- bus_wr  out  1  1 = write
- bus_strb  out  4  byte strobes; 0000 for reads
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_wdata  out  32  write data
- bus_gnt  in  1  address phase accepted
- bus_rvalid  in  1  response valid (read data or write ack)
- bus_rdata  in  32  read data
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- FSM states: IDLE, ADDR, RESP, DONE.
- Reset values: state=IDLE, bus_req=0, bus_wr=0, bus_strb=0, bus_addr=0, bus_wdata=0, data_sram_rdata=0, bus_err=0, counter=0.
- IDLE:
  - If data_sram_en=1, latch addr/wen/wdata into bus regs and go to ADDR.
  - stallreq = data_sram_en (combinational), so the pipeline stalls in the request cycle.
- ADDR:
  - bus_req=1; request fields held stable.
  - bus_gnt=1 with bus_rvalid=0 → RESP; bus_req drops next cycle.
  - bus_gnt=1 with bus_rvalid=1 in the same cycle → DONE, capturing the response.
  - stallreq=1.
- RESP:
  - bus_rvalid=1 → DONE. For a read, register bus_rdata into data_sram_rdata.
  - stallreq=1.
- DONE:
  - stallreq=0; the pipeline advances on this edge.
  - Unconditional transition to IDLE; the still-present en of the completed instruction is not re-issued.
- Writes leave data_sram_rdata unchanged. data_sram_rdata holds its value until the next completed read.
- Latency, zero-wait bus (gnt and rvalid in the first ADDR cycle): request cycle + ADDR + DONE, i.e. stallreq high for 2 cycles.
- Timeout:
  - Counter clears on IDLE→ADDR and increments each cycle in ADDR or RESP.
  - When the counter reaches TIMEOUT with no response, pulse bus_err and go to DONE.
  - Reads return ERR_RDATA; bus_req deasserts.
- bus_rvalid is ignored in IDLE and DONE, which covers stray responses after a timeout or reset.
- rst mid-transaction → IDLE next cycle, bus_req=0, stallreq follows data_sram_en. The request is reissued if en stays high.
- Back-to-back accesses: each completes DONE→IDLE before the next is accepted. Minimum spacing is 3 cycles per access.

Test Plan:
- Read, zero-wait: en=1, wen=0, addr=0x1000_0006; gnt and rvalid together in the first ADDR cycle, rdata=0xCAFEBABE → bus_addr=0x1000_0004, bus_strb=0000, stallreq high 2 cycles, data_sram_rdata=0xCAFEBABE in DONE and held afterwards.
- Byte write, delayed: wen=0100, wdata=0x00AB0000; gnt after 3 cycles, rvalid 2 cycles later → bus_req high 4 cycles, bus_wr=1, bus_strb=0100, stallreq low only in DONE, data_sram_rdata unchanged.
- Timeout: TIMEOUT=8, read with gnt and rvalid never asserted → bus_err pulses exactly once, data_sram_rdata=ERR_RDATA, FSM returns to IDLE; a later rvalid=1 with rdata=0x1234 is ignored.
- Reset mid-RESP: rst pulses while waiting for rvalid → next cycle bus_req=0, state IDLE, data_sram_rdata=0; a subsequent read completes normally.
- Back-to-back: read 0x100 then write 0x104, pipeline advancing on stallreq=0 → exactly two bus transactions, no duplicate issue in DONE.
- Idle: en=0 for 20 cycles → bus_req=0, stallreq=0 throughout.

Source files
------------

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
// Responder for the core's data-SRAM port. Each SRAM-style request from the
// execute stage becomes one transaction on a request/grant/response bus. The
// pipeline is held with stallreq until that transaction completes.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   data_sram_en      access request from execute stage
//   data_sram_wen     byte write enables (0 = read)
//   data_sram_addr    byte address
//   data_sram_wdata   lane-aligned store data
//   data_sram_rdata   load data, valid from the cycle after stallreq drops
//   stallreq          pipeline stall request
//   bus_req/wr/strb/addr/wdata   address phase toward the arbiter
//   bus_gnt           address phase accepted
//   bus_rvalid/rdata  response (read data or write ack)
//   bus_err           one-cycle pulse when a transaction times out
module data_sram_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_strb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timed_out;

    // The bus always transfers whole words; the byte offset is carried by the
    // strobes, so the low address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^data_sram_addr[1:0];

    // wait_cnt counts waiting cycles already spent; this is the last one allowed.
    assign timed_out = (wait_cnt == LAST_WAIT);

    // The request cycle itself must stall, hence the combinational path from
    // data_sram_en while idle. DONE releases the pipeline for exactly one edge.
    always_comb begin
        stallreq = 1'b0;
        case (state)
            IDLE:    stallreq = data_sram_en;
            ADDR:    stallreq = 1'b1;
            RESP:    stallreq = 1'b1;
            default: stallreq = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= 8'd0;
            bus_req         <= 1'b0;
            bus_wr          <= 1'b0;
            bus_strb        <= 4'b0000;
            bus_addr        <= 32'd0;
            bus_wdata       <= 32'd0;
            data_sram_rdata <= 32'd0;
            bus_err         <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= |data_sram_wen;
                        bus_strb  <= data_sram_wen;
                        bus_addr  <= {data_sram_addr[31:2], 2'b00};
                        bus_wdata <= data_sram_wdata;
                        wait_cnt  <= 8'd0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_gnt && bus_rvalid) begin
                        // Grant and response in the same cycle: skip RESP.
                        bus_req <= 1'b0;
                        if (!bus_wr) data_sram_rdata <= bus_rdata;
                        state <= DONE;
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!bus_wr) data_sram_rdata <= ERR_RDATA;
                        state <= DONE;
                    end else if (bus_gnt) begin
                        bus_req  <= 1'b0;
                        wait_cnt <= wait_cnt + 8'd1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        if (!bus_wr) data_sram_rdata <= bus_rdata;
                        state <= DONE;
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                        if (!bus_wr) data_sram_rdata <= ERR_RDATA;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    // The en still held by the completing instruction must
                    // not start a second transaction.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: a bus responder with programmable grant and
// response delays, plus scoreboards of expected bus requests and load data.
module tb_data_sram_bridge;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam logic [31:0] TB_ERR     = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_txn_t;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_strb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int issues = 0;
    logic [31:0] last_rd = 32'd0;

    bus_txn_t    bus_q[$];
    logic [31:0] rd_q[$];

    data_sram_bridge #(
        .TIMEOUT  (TB_TIMEOUT),
        .ERR_RDATA(TB_ERR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq       (stallreq),
        .bus_req        (bus_req),
        .bus_wr         (bus_wr),
        .bus_strb       (bus_strb),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted address phases on the bus.
    always @(posedge clk) begin
        if (!rst && bus_req && bus_gnt) issues <= issues + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // One access from the pipeline. Called at a negedge; returns at the
    // negedge where the DONE cycle is observed.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gdly, input int rdly,
                          input logic [31:0] rdat, input logic [31:0] exp_rd,
                          input bit release_en,
                          output int stall_n, output int req_n, output int err_n);
        bus_txn_t    cur;
        bit          have;
        bit          granted;
        bit          fin;
        int          addr_cyc;
        int          resp_cyc;
        logic [31:0] exp;
        cur = '0; have = 0; granted = 0; fin = 0; addr_cyc = 0; resp_cyc = 0;
        stall_n = 0; req_n = 0; err_n = 0;
        bus_q.push_back('{addr: {addr[31:2], 2'b00}, wr: (wen != 4'b0000),
                          strb: wen, wdata: wdata});
        if (wen == 4'b0000) rd_q.push_back(exp_rd);
        data_sram_en = 1'b1; data_sram_wen = wen;
        data_sram_addr = addr; data_sram_wdata = wdata;
        #1;
        if (stallreq) stall_n++;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (bus_err) err_n++;
            if (bus_req) begin
                req_n++; addr_cyc++;
                if (!have && bus_q.size() > 0) begin
                    cur = bus_q.pop_front(); have = 1;
                end
                checks++;
                if (bus_req !== bus_req || {bus_addr, bus_wr, bus_strb, bus_wdata} !== cur) begin
                    errors++;
                    $display("FAIL bus_fields: got addr=%h wr=%b strb=%b wdata=%h, want addr=%h wr=%b strb=%b wdata=%h",
                             bus_addr, bus_wr, bus_strb, bus_wdata, cur.addr, cur.wr, cur.strb, cur.wdata);
                end
                if (addr_cyc == gdly + 1) begin
                    bus_gnt = 1'b1; granted = 1;
                    if (rdly == 0) begin bus_rvalid = 1'b1; bus_rdata = rdat; end
                end
            end
            if (stallreq) begin
                stall_n++;
                if (!bus_req && granted) begin
                    resp_cyc++;
                    if (resp_cyc == rdly) begin bus_rvalid = 1'b1; bus_rdata = rdat; end
                end
            end else begin
                fin = 1;
                checks++;
                if (bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL done_bus_req: got %b, want 0", bus_req);
                end
                if (wen == 4'b0000) begin
                    exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hx;
                    last_rd = exp;
                end else begin
                    exp = last_rd;
                end
                checks++;
                if (data_sram_rdata !== exp) begin
                    errors++;
                    $display("FAIL done_rdata: got %h, want %h", data_sram_rdata, exp);
                end
                if (release_en) data_sram_en = 1'b0;
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL access_timeout: stallreq=%b still high, want completion within 100 cycles", stallreq);
            data_sram_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_sram_en = 1'b0; data_sram_wen = 4'b0000;
        data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_req, bus_wr, bus_strb, bus_err, stallreq} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b wr=%b strb=%b err=%b stall=%b, want all 0",
                     bus_req, bus_wr, bus_strb, bus_err, stallreq);
        end
        checks++;
        if ({bus_addr, bus_wdata, data_sram_rdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, want 0", bus_addr, bus_wdata, data_sram_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_zero_wait();
        int s, r, e;
        access(4'b0000, 32'h1000_0006, 32'd0, 0, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 1, s, r, e);
        checks++;
        if (s != 2 || r != 1 || e != 0) begin
            errors++;
            $display("FAIL read_zw_timing: got stall=%0d req=%0d err=%0d, want 2 1 0", s, r, e);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL read_zw_hold: got %h, want cafebabe", data_sram_rdata);
        end
    endtask

    task automatic test_write_delayed();
        int s, r, e;
        access(4'b0100, 32'h1000_0012, 32'h00AB_0000, 3, 2, 32'hFFFF_FFFF, 32'd0, 1, s, r, e);
        checks++;
        if (s != 7 || r != 4 || e != 0) begin
            errors++;
            $display("FAIL write_timing: got stall=%0d req=%0d err=%0d, want 7 4 0", s, r, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_resp();
        data_sram_en = 1'b1; data_sram_wen = 4'b0000;
        data_sram_addr = 32'h2000_0000; data_sram_wdata = 32'd0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_addr: bus_req got %b, want 1", bus_req);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || stallreq !== 1'b1) begin
            errors++; $display("FAIL rst_mid_resp: got req=%b stall=%b, want 0 1", bus_req, stallreq);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || data_sram_rdata !== 32'd0 || stallreq !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: got req=%b rdata=%h stall=%b, want 0 00000000 1",
                     bus_req, data_sram_rdata, stallreq);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h2000_0000) begin
            errors++;
            $display("FAIL rst_reissue: got req=%b addr=%h, want 1 20000000", bus_req, bus_addr);
        end
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h55AA_1234;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        checks++;
        if (stallreq !== 1'b0 || data_sram_rdata !== 32'h55AA_1234) begin
            errors++;
            $display("FAIL rst_followup_read: got stall=%b rdata=%h, want 0 55aa1234", stallreq, data_sram_rdata);
        end
        last_rd = 32'h55AA_1234;
        data_sram_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int s, r, e, extra;
        access(4'b0000, 32'h3000_0000, 32'd0, 1000, 0, 32'd0, TB_ERR, 1, s, r, e);
        checks++;
        if (s != 1 + int'(TB_TIMEOUT) || e != 1) begin
            errors++;
            $display("FAIL timeout_timing: got stall=%0d err=%0d, want %0d 1", s, e, 1 + TB_TIMEOUT);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_err) extra++;
            bus_rvalid = 1'b1; bus_rdata = 32'h0000_1234;
        end
        @(negedge clk);
        bus_rvalid = 1'b0;
        checks++;
        if (extra != 0 || data_sram_rdata !== TB_ERR || bus_req !== 1'b0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL timeout_stray: got extra_err=%0d rdata=%h req=%b stall=%b, want 0 %h 0 0",
                     extra, data_sram_rdata, bus_req, stallreq, TB_ERR);
        end
    endtask

    task automatic test_back_to_back();
        int s, r, e, base;
        base = issues;
        access(4'b0000, 32'h0000_0100, 32'd0, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, s, r, e);
        checks++;
        if (s != 2) begin
            errors++; $display("FAIL b2b_read_stall: got %0d, want 2", s);
        end
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL b2b_no_dup: bus_req got %b, want 0", bus_req);
        end
        access(4'b1111, 32'h0000_0104, 32'h1122_3344, 0, 1, 32'd0, 32'd0, 1, s, r, e);
        checks++;
        if (s != 3) begin
            errors++; $display("FAIL b2b_write_stall: got %0d, want 3", s);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (issues - base != 2) begin
            errors++; $display("FAIL b2b_issue_count: got %0d, want 2", issues - base);
        end
    endtask

    task automatic test_idle();
        data_sram_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus_req !== 1'b0 || stallreq !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: cycle %0d got req=%b stall=%b, want 0 0", i, bus_req, stallreq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_delayed();
        test_reset_mid_resp();
        test_timeout();
        test_back_to_back();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
